// File: rtl/sccb_pkg.sv
// Shared SCCB responder types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        SUB,
        SUB_ACK,
        DATA,
        DATA_ACK,
        RD_DATA,
        RD_NA,
        WAIT_STOP
    } state_t;

    localparam logic [7:0] OV7670_WR_ID  = 8'h42;
    localparam logic [7:0] OV7670_RD_ID  = 8'h43;
    localparam int         BITS_PER_BYTE = 8;

endpackage

// File: rtl/sccb_bus_monitor.sv
// Synchronises SIOC/SIOD and flags clock edges plus START/STOP conditions.
// Latency: SYNC_STAGES clk to the pulse, consumed by the FSM one clk later.
// Backpressure: none; pulses are single-cycle and must be consumed immediately.
module sccb_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sioc_in,
    input  logic siod_in,
    output logic sioc_rise,
    output logic sioc_fall,
    output logic start_det,
    output logic stop_det,
    output logic siod_sync
);

    logic [SYNC_STAGES-1:0] sioc_sync_q;
    logic [SYNC_STAGES-1:0] siod_sync_q;
    logic                   sioc_q;
    logic                   siod_q;
    logic                   sioc_d;
    logic                   siod_d;

    assign sioc_d = sioc_sync_q[SYNC_STAGES-1];
    assign siod_d = siod_sync_q[SYNC_STAGES-1];

    // Preset to 1 so a reset on an idle bus never looks like START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_q      <= 1'b1;
            siod_q      <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc_in};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_in};
            sioc_q      <= sioc_d;
            siod_q      <= siod_d;
        end
    end

    assign sioc_rise = sioc_d & ~sioc_q;
    assign sioc_fall = ~sioc_d & sioc_q;
    assign start_det = sioc_d & sioc_q & siod_q & ~siod_d;
    assign stop_det  = sioc_d & sioc_q & ~siod_q & siod_d;
    assign siod_sync = siod_d;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder decoding 3-phase write, 2-phase write and 2-phase read onto a register port.
// Latency: write strobe one clk after the 8th data bit is sampled; SIOD updates on SIOC falls.
// Backpressure: none; the register file must accept a strobe every cycle it is issued.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID   = OV7670_WR_ID,
    parameter int         ACK_ENABLE  = 1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rd_data,
    output logic       reg_rd_en,
    output logic       busy
);

    localparam logic [7:0] READ_ID  = DEVICE_ID | 8'h01;
    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

    logic       sioc_rise;
    logic       sioc_fall;
    logic       start_det;
    logic       stop_det;
    logic       siod_s;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [6:0] shift_q;
    logic [6:0] rd_shift;
    logic       rd_dir;
    logic       ack_phase;
    logic [7:0] byte_in;

    sccb_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_monitor (
        .clk       (clk),
        .rst       (rst),
        .sioc_in   (sioc_in),
        .siod_in   (siod_in),
        .sioc_rise (sioc_rise),
        .sioc_fall (sioc_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .siod_sync (siod_s)
    );

    assign byte_in = {shift_q, siod_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            rd_shift    <= '0;
            rd_dir      <= 1'b0;
            ack_phase   <= 1'b0;
            siod_oe     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            // Bus conditions outrank any SIOC edge seen in the same cycle.
            if (stop_det) begin
                state     <= IDLE;
                busy      <= 1'b0;
                siod_oe   <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
            end else if (start_det) begin
                state     <= ID;
                busy      <= 1'b1;
                siod_oe   <= 1'b0;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    ID, SUB, DATA: begin
                        if (sioc_rise) begin
                            shift_q <= byte_in[6:0];
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                if (state == ID) begin
                                    if (byte_in == DEVICE_ID) begin
                                        rd_dir <= 1'b0;
                                        state  <= ID_ACK;
                                    end else if (byte_in == READ_ID) begin
                                        rd_dir <= 1'b1;
                                        state  <= ID_ACK;
                                    end else begin
                                        state  <= WAIT_STOP;
                                    end
                                end else if (state == SUB) begin
                                    reg_addr <= byte_in;
                                    state    <= SUB_ACK;
                                end else begin
                                    reg_wr_data <= byte_in;
                                    reg_wr_en   <= 1'b1;
                                    state       <= DATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // First fall opens the 9th bit, second fall closes it.
                    ID_ACK, SUB_ACK, DATA_ACK: begin
                        if (sioc_fall) begin
                            if (!ack_phase) begin
                                siod_oe   <= (ACK_ENABLE != 0);
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                siod_oe   <= 1'b0;
                                if (state == ID_ACK && rd_dir) begin
                                    state     <= RD_DATA;
                                    siod_oe   <= ~reg_rd_data[7];
                                    rd_shift  <= reg_rd_data[6:0];
                                    reg_rd_en <= 1'b1;
                                    bit_cnt   <= '0;
                                end else if (state == ID_ACK) begin
                                    state <= SUB;
                                end else if (state == SUB_ACK) begin
                                    state <= DATA;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sioc_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                siod_oe <= 1'b0;
                                state   <= RD_NA;
                            end else begin
                                siod_oe  <= ~rd_shift[6];
                                rd_shift <= {rd_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_NA: begin
                        if (sioc_fall) begin
                            state <= WAIT_STOP;
                        end
                    end
                    default: begin
                        siod_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bit-banged SCCB master driving an ACK-enabled and an ACK-disabled responder in parallel.
module tb_sccb_target;
    import sccb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic [7:0] rd_data = 8'h76;

    logic       oe0, wr_en0, rd_en0, busy0;
    logic [7:0] addr0, wdata0;
    logic       oe1, wr_en1, rd_en1, busy1;
    logic [7:0] addr1, wdata1;
    logic       line0, line1;

    assign line0 = sda & ~oe0;
    assign line1 = sda & ~oe1;

    sccb_target #(.DEVICE_ID(8'h42), .ACK_ENABLE(1), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .sioc_in(scl), .siod_in(line0), .siod_oe(oe0),
        .reg_addr(addr0), .reg_wr_data(wdata0), .reg_wr_en(wr_en0),
        .reg_rd_data(rd_data), .reg_rd_en(rd_en0), .busy(busy0)
    );

    sccb_target #(.DEVICE_ID(8'h42), .ACK_ENABLE(0), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .sioc_in(scl), .siod_in(line1), .siod_oe(oe1),
        .reg_addr(addr1), .reg_wr_data(wdata1), .reg_wr_en(wr_en1),
        .reg_rd_data(rd_data), .reg_rd_en(rd_en1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         wr_cnt0 = 0, wr_cnt1 = 0, rd_cnt0 = 0, rd_cnt1 = 0;
    int         oe_hi0 = 0, oe_hi1 = 0;
    logic [7:0] cap_addr0 = '0, cap_data0 = '0, cap_addr1 = '0, cap_data1 = '0;

    always @(negedge clk) begin
        if (wr_en0) begin wr_cnt0++; cap_addr0 = addr0; cap_data0 = wdata0; end
        if (wr_en1) begin wr_cnt1++; cap_addr1 = addr1; cap_data1 = wdata1; end
        if (rd_en0) rd_cnt0++;
        if (rd_en1) rd_cnt1++;
        if (oe0) oe_hi0++;
        if (oe1) oe_hi1++;
    end

    typedef struct {
        logic [7:0] id, sub, dat;
        bit         three;
        int         exp_wr;
        logic [7:0] exp_addr, exp_wdat;
        logic [2:0] exp_ack;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic quarter();
        repeat (8) @(negedge clk);
    endtask

    task automatic bus_start();
        sda = 1'b1; quarter(); scl = 1'b1; quarter(); sda = 1'b0; quarter(); scl = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        sda = 1'b0; quarter(); scl = 1'b1; quarter(); sda = 1'b1; quarter(); quarter();
    endtask

    task automatic put_bit(input logic b);
        sda = b; quarter(); scl = 1'b1; quarter(); quarter(); scl = 1'b0; quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        sda = 1'b1; quarter(); scl = 1'b1; quarter();
        ack = ~line0;
        quarter(); scl = 1'b0; quarter();
    endtask

    task automatic read_byte(output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda = 1'b1; quarter(); scl = 1'b1; quarter();
            d[i] = line0;
            quarter(); scl = 1'b0; quarter();
        end
        put_bit(1'b1);
    endtask

    task automatic write_txn(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                             input bit three, output logic [2:0] acks);
        logic a0, a1, a2;
        a2 = 1'b0;
        bus_start();
        chk("busy_after_start", busy0, 1'b1);
        send_byte(id, a0);
        send_byte(sub, a1);
        if (three) send_byte(dat, a2);
        bus_stop();
        acks = {a2, a1, a0};
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int         w0, w1, o0, o1, r0;
        logic [2:0] acks;
        logic       a;
        logic [7:0] d;

        vecs[0] = '{8'h42, 8'h12, 8'h80, 1'b1, 1, 8'h12, 8'h80, 3'b111};
        vecs[1] = '{8'h60, 8'h12, 8'h34, 1'b1, 0, 8'h12, 8'h00, 3'b000};
        vecs[2] = '{8'h42, 8'h0A, 8'h00, 1'b0, 0, 8'h0A, 8'h00, 3'b011};
        vecs[3] = '{8'h42, 8'h11, 8'h01, 1'b1, 1, 8'h11, 8'h01, 3'b111};
        vecs[4] = '{8'h42, 8'hFF, 8'h00, 1'b1, 1, 8'hFF, 8'h00, 3'b111};

        repeat (4) @(negedge clk);
        chk("rst_siod_oe", oe0, 1'b0);
        chk("rst_reg_addr", addr0, 8'h00);
        chk("rst_wr_data", wdata0, 8'h00);
        chk("rst_wr_en", wr_en0, 1'b0);
        chk("rst_rd_en", rd_en0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        rst = 1'b0;
        quarter();

        for (int v = 0; v < 5; v++) begin
            w0 = wr_cnt0; w1 = wr_cnt1; o0 = oe_hi0; o1 = oe_hi1;
            write_txn(vecs[v].id, vecs[v].sub, vecs[v].dat, vecs[v].three, acks);
            chk("vec_acks", acks, vecs[v].exp_ack);
            chk("vec_wr_count", wr_cnt0 - w0, vecs[v].exp_wr);
            if (vecs[v].exp_wr == 1) begin
                chk("vec_wr_addr", cap_addr0, vecs[v].exp_addr);
                chk("vec_wr_data", cap_data0, vecs[v].exp_wdat);
                chk("noack_wr_addr", cap_addr1, vecs[v].exp_addr);
                chk("noack_wr_data", cap_data1, vecs[v].exp_wdat);
            end
            chk("vec_reg_addr", addr0, vecs[v].exp_addr);
            chk("vec_busy_idle", busy0, 1'b0);
            chk("vec_oe_used", oe_hi0 != o0, vecs[v].exp_ack != 3'b000);
            chk("noack_oe_never", oe_hi1 - o1, 0);
            chk("noack_wr_count", wr_cnt1 - w1, vecs[v].exp_wr);
            chk("noack_reg_addr", addr1, vecs[v].exp_addr);
        end

        // Read after a 2-phase write sets the sub-address.
        write_txn(8'h42, 8'h0A, 8'h00, 1'b0, acks);
        chk("rd_setup_acks", acks, 3'b011);
        w0 = wr_cnt0; r0 = rd_cnt0;
        bus_start();
        send_byte(OV7670_RD_ID, a);
        chk("rd_id_ack", a, 1'b1);
        read_byte(d);
        bus_stop();
        chk("rd_data_on_bus", d, 8'h76);
        chk("rd_en_count", rd_cnt0 - r0, 1);
        chk("rd_no_write", wr_cnt0 - w0, 0);
        chk("rd_reg_addr", addr0, 8'h0A);
        chk("rd_busy_idle", busy0, 1'b0);

        // STOP in the middle of the data byte discards it.
        w0 = wr_cnt0;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h20, a);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        bus_stop();
        chk("partial_no_write", wr_cnt0 - w0, 0);
        chk("partial_reg_addr", addr0, 8'h20);
        chk("partial_busy", busy0, 1'b0);

        // Repeated START four bits into the data byte, then a full write.
        w0 = wr_cnt0;
        bus_start();
        send_byte(8'h42, a);
        send_byte(8'h55, a);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b1); put_bit(1'b1);
        bus_start();
        chk("rs_busy", busy0, 1'b1);
        send_byte(8'h42, a);
        send_byte(8'h3A, a);
        send_byte(8'h04, a);
        bus_stop();
        chk("rs_wr_count", wr_cnt0 - w0, 1);
        chk("rs_wr_addr", cap_addr0, 8'h3A);
        chk("rs_wr_data", cap_data0, 8'h04);

        // Reset while the responder is holding the ID acknowledge.
        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(vecs[0].id[i]);
        sda = 1'b1; quarter(); scl = 1'b1; quarter();
        chk("ack_before_rst", oe0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_oe", oe0, 1'b0);
        chk("rst_mid_busy", busy0, 1'b0);
        chk("rst_mid_addr", addr0, 8'h00);
        chk("rst_mid_wdata", wdata0, 8'h00);
        chk("rst_mid_wr_en", wr_en0, 1'b0);
        chk("rst_mid_rd_en", rd_en0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        quarter(); scl = 1'b0; quarter();
        bus_stop();
        w0 = wr_cnt0;
        write_txn(8'h42, 8'h12, 8'h80, 1'b1, acks);
        chk("post_rst_acks", acks, 3'b111);
        chk("post_rst_wr_count", wr_cnt0 - w0, 1);
        chk("post_rst_wr_addr", cap_addr0, 8'h12);
        chk("post_rst_wr_data", cap_data0, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
